blob_bbox_tracker: RTL and testbench

BLOB_BBOX_TRACKER -- requirements
Module: blob_bbox_tracker

---
 rtl/blob_bbox_tracker.sv | 236 +++++++++++++++++++++++
 tb/tb_blob_bbox_tracker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_bbox_tracker.sv
// Tracks the bounding box and matched-pixel count of a red blob across each camera frame.
// Define BLOB_CENTROID_EN to also accumulate the x/y coordinate sums of matched pixels.
module blob_bbox_tracker #(
  parameter int IMG_W     = 320,
  parameter int IMG_H     = 240,
  parameter int R_MIN     = 20,
  parameter int G_MAX     = 24,
  parameter int B_MAX     = 12,
  parameter int MIN_COUNT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vsync,
  input  logic        we,
  input  logic [15:0] wData,
  output logic        frame_done,
  output logic        found,
  output logic [8:0]  x_min,
  output logic [8:0]  x_max,
  output logic [7:0]  y_min,
  output logic [7:0]  y_max,
  output logic [16:0] pix_count,
  output logic [24:0] sum_x,
  output logic [24:0] sum_y
);
  localparam logic [8:0]  X_LAST  = 9'(IMG_W - 1);
  localparam logic [8:0]  Y_END   = 9'(IMG_H);
  localparam logic [4:0]  R_LO    = 5'(R_MIN);
  localparam logic [5:0]  G_HI    = 6'(G_MAX);
  localparam logic [4:0]  B_HI    = 5'(B_MAX);
  localparam logic [16:0] CNT_MIN = 17'(MIN_COUNT);
  localparam logic [16:0] CNT_SAT = 17'd76800;

  typedef enum logic [1:0] {SYNC, ACTIVE, DRAIN, LATCH} state_t;

  state_t      state_q, state_d;
  logic        vsync_q;
  logic        skip_q, skip_d;
  logic        drain_q, drain_d;
  logic [8:0]  x_q, x_d, y_q, y_d;
  logic        s1_valid_q, s1_valid_d;
  logic [8:0]  s1_x_q, s1_x_d;
  logic [7:0]  s1_y_q, s1_y_d;
  logic [16:0] cnt_q, cnt_d;
  logic [8:0]  bx_min_q, bx_min_d, bx_max_q, bx_max_d;
  logic [7:0]  by_min_q, by_min_d, by_max_q, by_max_d;
  logic        frame_done_q, frame_done_d, found_q, found_d;
  logic [8:0]  x_min_q, x_min_d, x_max_q, x_max_d;
  logic [7:0]  y_min_q, y_min_d, y_max_q, y_max_d;
  logic [16:0] pix_count_q, pix_count_d;

  logic vsync_rise, pix_ok, pix_match, count_en, acc_clear, publish, found_now;

  assign vsync_rise = vsync & ~vsync_q;
  assign pix_ok     = we && (state_q == ACTIVE) && (y_q < Y_END);
  assign pix_match  = (wData[15:11] >= R_LO) && (wData[10:5] <= G_HI) && (wData[4:0] <= B_HI);
  assign count_en   = s1_valid_q && (cnt_q < CNT_SAT);
  assign acc_clear  = (state_q == LATCH);
  // The LATCH pass that follows SYNC only clears state; it must not publish a partial frame.
  assign publish    = acc_clear && !skip_q;
  assign found_now  = (cnt_q >= CNT_MIN);

  always_comb begin
    state_d      = state_q;
    skip_d       = skip_q;
    drain_d      = drain_q;
    x_d          = x_q;
    y_d          = y_q;
    s1_valid_d   = pix_ok && pix_match;
    s1_x_d       = x_q;
    s1_y_d       = y_q[7:0];
    cnt_d        = cnt_q;
    bx_min_d     = bx_min_q;
    bx_max_d     = bx_max_q;
    by_min_d     = by_min_q;
    by_max_d     = by_max_q;
    frame_done_d = 1'b0;
    found_d      = found_q;
    x_min_d      = x_min_q;
    x_max_d      = x_max_q;
    y_min_d      = y_min_q;
    y_max_d      = y_max_q;
    pix_count_d  = pix_count_q;

    if (pix_ok) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 9'd1;
      end else begin
        x_d = x_q + 9'd1;
      end
    end

    if (s1_valid_q) begin
      if (cnt_q == '0) begin
        bx_min_d = s1_x_q;
        bx_max_d = s1_x_q;
        by_min_d = s1_y_q;
        by_max_d = s1_y_q;
      end else begin
        if (s1_x_q < bx_min_q) bx_min_d = s1_x_q;
        if (s1_x_q > bx_max_q) bx_max_d = s1_x_q;
        if (s1_y_q < by_min_q) by_min_d = s1_y_q;
        if (s1_y_q > by_max_q) by_max_d = s1_y_q;
      end
    end
    if (count_en) cnt_d = cnt_q + 17'd1;

    if (publish) begin
      frame_done_d = 1'b1;
      found_d      = found_now;
      x_min_d      = found_now ? bx_min_q : '0;
      x_max_d      = found_now ? bx_max_q : '0;
      y_min_d      = found_now ? by_min_q : '0;
      y_max_d      = found_now ? by_max_q : '0;
      pix_count_d  = cnt_q;
    end
    if (acc_clear) begin
      cnt_d    = '0;
      bx_min_d = '0;
      bx_max_d = '0;
      by_min_d = '0;
      by_max_d = '0;
      x_d      = '0;
      y_d      = '0;
    end

    case (state_q)
      SYNC:    if (vsync_rise) begin state_d = LATCH; skip_d = 1'b1; end
      ACTIVE:  if (vsync_rise) begin state_d = DRAIN; drain_d = 1'b0; end
      DRAIN:   if (drain_q) state_d = LATCH; else drain_d = 1'b1;
      LATCH:   begin state_d = ACTIVE; skip_d = 1'b0; end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    vsync_q <= vsync;
    if (reset) begin
      state_q      <= SYNC;
      skip_q       <= 1'b0;
      drain_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      cnt_q        <= '0;
      bx_min_q     <= '0;
      bx_max_q     <= '0;
      by_min_q     <= '0;
      by_max_q     <= '0;
      frame_done_q <= 1'b0;
      found_q      <= 1'b0;
      x_min_q      <= '0;
      x_max_q      <= '0;
      y_min_q      <= '0;
      y_max_q      <= '0;
      pix_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      skip_q       <= skip_d;
      drain_q      <= drain_d;
      x_q          <= x_d;
      y_q          <= y_d;
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s1_y_q       <= s1_y_d;
      cnt_q        <= cnt_d;
      bx_min_q     <= bx_min_d;
      bx_max_q     <= bx_max_d;
      by_min_q     <= by_min_d;
      by_max_q     <= by_max_d;
      frame_done_q <= frame_done_d;
      found_q      <= found_d;
      x_min_q      <= x_min_d;
      x_max_q      <= x_max_d;
      y_min_q      <= y_min_d;
      y_max_q      <= y_max_d;
      pix_count_q  <= pix_count_d;
    end
  end

  assign frame_done = frame_done_q;
  assign found      = found_q;
  assign x_min      = x_min_q;
  assign x_max      = x_max_q;
  assign y_min      = y_min_q;
  assign y_max      = y_max_q;
  assign pix_count  = pix_count_q;

`ifdef BLOB_CENTROID_EN
  logic [24:0] acc_sx_q, acc_sx_d, acc_sy_q, acc_sy_d;
  logic [24:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d;

  always_comb begin
    acc_sx_d = acc_sx_q;
    acc_sy_d = acc_sy_q;
    sum_x_d  = sum_x_q;
    sum_y_d  = sum_y_q;
    if (count_en) begin
      acc_sx_d = acc_sx_q + 25'(s1_x_q);
      acc_sy_d = acc_sy_q + 25'(s1_y_q);
    end
    if (publish) begin
      sum_x_d = acc_sx_q;
      sum_y_d = acc_sy_q;
    end
    if (acc_clear) begin
      acc_sx_d = '0;
      acc_sy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_sx_q <= '0;
      acc_sy_q <= '0;
      sum_x_q  <= '0;
      sum_y_q  <= '0;
    end else begin
      acc_sx_q <= acc_sx_d;
      acc_sy_q <= acc_sy_d;
      sum_x_q  <= sum_x_d;
      sum_y_q  <= sum_y_d;
    end
  end

  assign sum_x = sum_x_q;
  assign sum_y = sum_y_q;
`else
  assign sum_x = '0;
  assign sum_y = '0;
`endif

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Bench for blob_bbox_tracker: hand-computed frame vectors, random frames against a
// frame-level reference model, and reset-in-frame / reset-in-drain sequences.
module tb_blob_bbox_tracker;
  localparam int W    = 120;
  localparam int H    = 64;
  localparam int MINC = 64;

  logic        clk = 1'b0;
  logic        reset, vsync, we;
  logic [15:0] wData;
  logic        frame_done, found;
  logic [8:0]  x_min, x_max;
  logic [7:0]  y_min, y_max;
  logic [16:0] pix_count;
  logic [24:0] sum_x, sum_y;

  always #5 clk = ~clk;

  blob_bbox_tracker #(
    .IMG_W(W), .IMG_H(H), .R_MIN(20), .G_MAX(24), .B_MAX(12), .MIN_COUNT(MINC)
  ) dut (
    .clk(clk), .reset(reset), .vsync(vsync), .we(we), .wData(wData),
    .frame_done(frame_done), .found(found),
    .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .pix_count(pix_count), .sum_x(sum_x), .sum_y(sum_y)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] pix [8192];
  int doneLatency, donePulses;

  typedef struct {
    string name;
    int n;
    int rx0, rx1, ry0, ry1;
    int eFound, eXMin, eXMax, eYMin, eYMax, eCnt, eSumX, eSumY;
  } vec_t;
  vec_t vecs [6];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rgb(input int r, input int g, input int b);
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  function automatic bit isMatch(input logic [15:0] p);
    return (int'(p[15:11]) >= 20) && (int'(p[10:5]) <= 24) && (int'(p[4:0]) <= 12);
  endfunction

  // Rectangle pixels alternate between strong red and the exact threshold colour;
  // the background cycles through black and three one-step-off near misses.
  task automatic fillRect(input int n, input int rx0, input int rx1, input int ry0, input int ry1);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = i % W;
      y = i / W;
      if (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1)
        pix[i] = (i % 2 == 1) ? rgb(20, 24, 12) : 16'hF800;
      else case (i % 4)
        0:       pix[i] = 16'h0000;
        1:       pix[i] = rgb(19, 0, 0);
        2:       pix[i] = rgb(31, 25, 0);
        default: pix[i] = rgb(31, 0, 13);
      endcase
    end
  endtask

  // Frame-level model: pixel k of a frame lands at (k mod W, k div W) while inside the frame.
  task automatic modelFrame(input int n, output int eFound, output int eXMin, output int eXMax,
                            output int eYMin, output int eYMax, output int eCnt,
                            output int eSumX, output int eSumY);
    int cnt, xmn, xmx, ymn, ymx, sx, sy;
    cnt = 0; xmn = 0; xmx = 0; ymn = 0; ymx = 0; sx = 0; sy = 0;
    for (int i = 0; i < n && i < W * H; i++) begin
      int x, y;
      x = i % W;
      y = i / W;
      if (isMatch(pix[i])) begin
        if (cnt == 0) begin
          xmn = x; xmx = x; ymn = y; ymx = y;
        end else begin
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
        if (cnt < 76800) begin
          cnt++;
          sx += x;
          sy += y;
        end
      end
    end
    eFound = (cnt >= MINC) ? 1 : 0;
    eXMin  = eFound ? xmn : 0;
    eXMax  = eFound ? xmx : 0;
    eYMin  = eFound ? ymn : 0;
    eYMax  = eFound ? ymx : 0;
    eCnt   = cnt;
    eSumX  = sx;
    eSumY  = sy;
  endtask

  // Drives pix[0..n-1] with optional idle gaps; the last write coincides with the vsync rise.
  // Matching writes are then injected into DRAIN/LATCH, and frame_done is watched for 10 cycles.
  task automatic applyStimulus(input int n, input int gapPct);
    vsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      int g;
      g = 0;
      while (g < 4 && int'($urandom_range(99)) < gapPct) begin
        we = 1'b0;
        tick();
        g++;
      end
      we    = 1'b1;
      wData = pix[i];
      vsync = (i == n - 1);
      tick();
    end
    doneLatency = -1;
    donePulses  = 0;
    for (int c = 0; c < 10; c++) begin
      if (frame_done) begin
        donePulses++;
        if (doneLatency < 0) doneLatency = c;
      end
      we    = (c < 3);
      wData = 16'hF800;
      if (c == 5) vsync = 1'b0;
      tick();
    end
    we    = 1'b0;
    vsync = 1'b0;
    tick();
  endtask

  task automatic drivePixels(input int n);
    for (int i = 0; i < n; i++) begin
      we    = 1'b1;
      wData = 16'hF800;
      tick();
    end
    we = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int eFound, input int eXMin, input int eXMax,
                             input int eYMin, input int eYMax, input int eCnt,
                             input int eSumX, input int eSumY);
    int sx, sy;
    sx = eSumX;
    sy = eSumY;
`ifndef BLOB_CENTROID_EN
    sx = 0;
    sy = 0;
`endif
    checkOutput({tag, ".latency"}, doneLatency, 3);
    checkOutput({tag, ".pulses"}, donePulses, 1);
    checkOutput({tag, ".found"}, int'(found), eFound);
    checkOutput({tag, ".x_min"}, int'(x_min), eXMin);
    checkOutput({tag, ".x_max"}, int'(x_max), eXMax);
    checkOutput({tag, ".y_min"}, int'(y_min), eYMin);
    checkOutput({tag, ".y_max"}, int'(y_max), eYMax);
    checkOutput({tag, ".pix_count"}, int'(pix_count), eCnt);
    checkOutput({tag, ".sum_x"}, int'(sum_x), sx);
    checkOutput({tag, ".sum_y"}, int'(sum_y), sy);
  endtask

  task automatic checkZero(input string tag);
    checkOutput({tag, ".frame_done"}, int'(frame_done), 0);
    checkOutput({tag, ".found"}, int'(found), 0);
    checkOutput({tag, ".x_min"}, int'(x_min), 0);
    checkOutput({tag, ".x_max"}, int'(x_max), 0);
    checkOutput({tag, ".y_min"}, int'(y_min), 0);
    checkOutput({tag, ".y_max"}, int'(y_max), 0);
    checkOutput({tag, ".pix_count"}, int'(pix_count), 0);
    checkOutput({tag, ".sum_x"}, int'(sum_x), 0);
    checkOutput({tag, ".sum_y"}, int'(sum_y), 0);
  endtask

  // A vsync rise out of SYNC only arms the tracker and must not produce frame_done.
  task automatic armSync(input string tag);
    int pulses;
    vsync = 1'b0;
    we    = 1'b0;
    tick();
    vsync  = 1'b1;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (frame_done) pulses++;
    end
    checkOutput({tag, ".no_done"}, pulses, 0);
    vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic runVec(input int k);
    fillRect(vecs[k].n, vecs[k].rx0, vecs[k].rx1, vecs[k].ry0, vecs[k].ry1);
    applyStimulus(vecs[k].n, (vecs[k].n > 1000) ? 0 : 25);
    checkResult(vecs[k].name, vecs[k].eFound, vecs[k].eXMin, vecs[k].eXMax, vecs[k].eYMin,
                vecs[k].eYMax, vecs[k].eCnt, vecs[k].eSumX, vecs[k].eSumY);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int eF, eX0, eX1, eY0, eY1, eC, eSX, eSY;

    vecs[0] = '{"square",   7200, 100, 109, 50, 59,  1, 100, 109, 50, 59, 100,  10450,  5450};
    vecs[1] = '{"below",     120,   0,  62,  0,  0,  0,   0,   0,  0,  0,  63,   1953,     0};
    vecs[2] = '{"atmin",     480,  10,  73,  3,  3,  1,  10,  73,  3,  3,  64,   2656,   192};
    vecs[3] = '{"corner",   7680,  56, 119, 63, 63,  1,  56, 119, 63, 63,  64,   5600,  4032};
    vecs[4] = '{"overflow", 8000,   0, 119,  0, 999, 1,   0, 119,  0, 63, 7680, 456960, 241920};
    vecs[5] = '{"empty",      50, 200, 200,  0,  0,  0,   0,   0,  0,  0,   0,      0,     0};

    reset = 1'b1;
    vsync = 1'b0;
    we    = 1'b0;
    wData = '0;
    repeat (3) tick();
    checkZero("reset");
    reset = 1'b0;
    tick();
    armSync("arm0");

    for (int k = 0; k < 6; k++) runVec(k);

    for (int f = 0; f < 4; f++) begin
      int n;
      n = int'($urandom_range(200, 1500));
      for (int i = 0; i < n; i++)
        pix[i] = rgb(int'($urandom_range(16, 31)), int'($urandom_range(0, 31)),
                     int'($urandom_range(0, 20)));
      modelFrame(n, eF, eX0, eX1, eY0, eY1, eC, eSX, eSY);
      applyStimulus(n, 30);
      checkResult($sformatf("rand%0d", f), eF, eX0, eX1, eY0, eY1, eC, eSX, eSY);
    end

    // Reset in the middle of a frame, then writes while in SYNC that must be ignored.
    drivePixels(300);
    reset = 1'b1;
    tick();
    tick();
    checkZero("rst_mid");
    reset = 1'b0;
    tick();
    drivePixels(200);
    armSync("arm1");
    runVec(2);

    // Reset while draining: the closing frame is dropped without a frame_done pulse.
    drivePixels(100);
    vsync = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
        if (frame_done) pulses++;
        tick();
      end
      checkOutput("rst_drain.no_done", pulses, 0);
    end
    checkZero("rst_drain");
    vsync = 1'b0;
    tick();
    armSync("arm2");
    runVec(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
